// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: ALU select, ALUOp and funct3 encodings shared by the ALU control queue.
package alu_ctrl_pkg;
  localparam logic [3:0] SEL_AND = 4'b0000;
  localparam logic [3:0] SEL_OR  = 4'b0001;
  localparam logic [3:0] SEL_ADD = 4'b0010;
  localparam logic [3:0] SEL_SUB = 4'b0110;
  localparam logic [3:0] SEL_ILL = 4'b1111;
  localparam logic [1:0] AOP_MEM = 2'b00;
  localparam logic [1:0] AOP_BR  = 2'b01;
  localparam logic [1:0] AOP_RI  = 2'b10;
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
endpackage

// File: rtl/alu_sel_decode.sv
// alu_sel_decode: combinational map of decoded instruction fields to {illegal, ALU sel}.
module alu_sel_decode
  import alu_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       op_5,
  output logic [3:0] sel,
  output logic       illegal
);
  logic [4:0] res;
  // op_5 gates subtraction so I-type immediates with bit 30 set still add
  always_comb begin
    res = alu_op == AOP_MEM ? {1'b0, SEL_ADD} :
          alu_op == AOP_BR  ? {1'b0, SEL_SUB} :
          alu_op != AOP_RI  ? {1'b1, SEL_ILL} :
          funct3 == F3_ADD  ? {1'b0, (funct7_5 && op_5) ? SEL_SUB : SEL_ADD} :
          funct3 == F3_AND  ? {1'b0, SEL_AND} :
          funct3 == F3_OR   ? {1'b0, SEL_OR} :
                              {1'b1, SEL_ILL};
  end
  assign {illegal, sel} = res;
endmodule

// File: rtl/alu_ctrl_queue.sv
// alu_ctrl_queue: decodes ALU control fields and buffers them in a FIFO between decode and execute.
// Optional issue/illegal statistics counters are built when ALU_CTRL_STATS_EN is defined.
module alu_ctrl_queue
  import alu_ctrl_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               alu_op,
  input  logic [2:0]               funct3,
  input  logic                     funct7_5,
  input  logic                     op_5,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [3:0]               sel,
  output logic                     illegal,
  output logic [$clog2(DEPTH):0]   count
`ifdef ALU_CTRL_STATS_EN
  ,
  output logic [CNT_W-1:0]         ops_issued,
  output logic [CNT_W-1:0]         ops_illegal
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CNT_W < 1) begin : g_bad_param
    $error("alu_ctrl_queue: DEPTH must be a power of two >= 2 and CNT_W >= 1");
  end
  logic [4:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [4:0]    dec, held, head;
  logic          push, pop;
  alu_sel_decode u_dec (
    .alu_op   (alu_op),
    .funct3   (funct3),
    .funct7_5 (funct7_5),
    .op_5     (op_5),
    .sel      (dec[3:0]),
    .illegal  (dec[4])
  );
  assign in_ready  = count != FULL;
  assign out_valid = count != '0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  // outputs come from storage only, so there is no input-to-output path
  assign head             = out_valid ? mem[rptr] : held;
  assign {illegal, sel}   = head;
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= dec;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      held  <= {1'b0, SEL_ADD};
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop) begin
        rptr <= rptr + AW'(1);
        held <= mem[rptr];
      end
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
`ifdef ALU_CTRL_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ops_issued  <= '0;
      ops_illegal <= '0;
    end else begin
      if (pop && !(&ops_issued)) ops_issued <= ops_issued + CNT_W'(1);
      if (pop && head[4] && !(&ops_illegal)) ops_illegal <= ops_illegal + CNT_W'(1);
    end
  end
`endif
endmodule

// File: tb/tb_alu_ctrl_queue.sv
// tb_alu_ctrl_queue: directed and random stimulus checked against a queue-based reference model.
module tb_alu_ctrl_queue;
  localparam int DEPTH = 2;
  localparam int CNT_W = 4;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic [1:0] alu_op = 0;
  logic [2:0] funct3 = 0;
  logic funct7_5 = 0, op_5 = 0;
  logic in_ready, out_valid, illegal;
  logic [3:0] sel;
  logic [$clog2(DEPTH):0] count;
`ifdef ALU_CTRL_STATS_EN
  logic [CNT_W-1:0] ops_issued, ops_illegal;
`endif
  int checks = 0, failures = 0;
  logic [4:0] q[$];
  logic [4:0] held;
  int n_iss, n_ill;

  alu_ctrl_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct3(funct3), .funct7_5(funct7_5), .op_5(op_5),
    .out_valid(out_valid), .out_ready(out_ready), .sel(sel), .illegal(illegal),
    .count(count)
`ifdef ALU_CTRL_STATS_EN
    , .ops_issued(ops_issued), .ops_illegal(ops_illegal)
`endif
  );

  always #5 clk = ~clk;

  // {illegal, sel} straight from the decode table
  function automatic logic [4:0] ref_dec(input logic [1:0] op, input logic [2:0] f3,
                                         input logic f7, input logic o5);
    case (op)
      2'd0: return 5'b00010;
      2'd1: return 5'b00110;
      2'd2: case (f3)
              3'd0:    return (f7 && o5) ? 5'b00110 : 5'b00010;
              3'd7:    return 5'b00000;
              3'd6:    return 5'b00001;
              default: return 5'b11111;
            endcase
      default: return 5'b11111;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    held  = 5'b00010;
    n_iss = 0;
    n_ill = 0;
  endtask

  task automatic check_outputs();
    logic [4:0] h;
    h = (q.size() != 0) ? q[0] : held;
    check("out_valid", 32'(out_valid), 32'(q.size() != 0));
    check("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
    check("count", 32'(count), 32'(q.size()));
    check("sel", 32'(sel), 32'(h[3:0]));
    check("illegal", 32'(illegal), 32'(h[4]));
`ifdef ALU_CTRL_STATS_EN
    check("ops_issued", 32'(ops_issued), 32'(n_iss));
    check("ops_illegal", 32'(ops_illegal), 32'(n_ill));
`endif
  endtask

  // one clock: drive inputs, check current outputs, then advance model and DUT together
  task automatic cyc(input logic v, input logic r, input logic [1:0] op, input logic [2:0] f3,
                     input logic f7, input logic o5);
    logic do_push, do_pop;
    logic [4:0] e;
    in_valid = v; out_ready = r; alu_op = op; funct3 = f3; funct7_5 = f7; op_5 = o5;
    #1;
    check_outputs();
    do_push = v && (q.size() < DEPTH);
    do_pop  = r && (q.size() != 0);
    e = ref_dec(op, f3, f7, o5);
    @(posedge clk);
    #1;
    if (do_pop) begin
      held = q.pop_front();
      if (n_iss < (1 << CNT_W) - 1) n_iss++;
      if (held[4] && n_ill < (1 << CNT_W) - 1) n_ill++;
    end
    if (do_push) q.push_back(e);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    check_outputs();
    // asynchronous reset with two entries queued
    cyc(1, 0, 2'd2, 3'd7, 0, 0);
    cyc(1, 0, 2'd2, 3'd6, 0, 0);
    in_valid = 0;
    check("count_before_rst", 32'(count), 32'd2);
    #2 rst = 1;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    model_reset();
    @(posedge clk);
    #1 rst = 0;
    // decode sweep
    cyc(1, 1, 2'd2, 3'd0, 1, 1);
    cyc(1, 1, 2'd2, 3'd0, 1, 0);
    cyc(1, 1, 2'd2, 3'd7, 0, 1);
    cyc(1, 1, 2'd2, 3'd6, 0, 1);
    cyc(1, 1, 2'd0, 3'd5, 1, 1);
    cyc(1, 1, 2'd1, 3'd3, 0, 0);
    // illegal operations
    cyc(1, 1, 2'd3, 3'd0, 0, 0);
    cyc(1, 1, 2'd2, 3'd1, 0, 1);
    cyc(0, 1, 2'd0, 3'd0, 0, 0);
    cyc(0, 1, 2'd0, 3'd0, 0, 0);
    cyc(0, 1, 2'd0, 3'd0, 0, 0);
    // fill, dropped third push, then drain in order
    cyc(1, 0, 2'd2, 3'd7, 0, 0);
    cyc(1, 0, 2'd2, 3'd6, 0, 0);
    cyc(1, 0, 2'd1, 3'd0, 0, 0);
    cyc(0, 1, 2'd0, 3'd0, 0, 0);
    cyc(0, 1, 2'd0, 3'd0, 0, 0);
    cyc(0, 1, 2'd0, 3'd0, 0, 0);
    // concurrent push/pop at occupancy 1
    cyc(1, 0, 2'd2, 3'd0, 1, 1);
    for (int i = 0; i < 10; i++)
      cyc(1, 1, 2'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
    // random traffic, long enough to saturate small counters
    for (int i = 0; i < 300; i++)
      cyc(1'($urandom), 1'($urandom), 2'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
    for (int i = 0; i < 3; i++)
      cyc(0, 1, 2'd0, 3'd0, 0, 0);
    check_outputs();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
